// File: rtl/param_sync_fifo_pkg.sv
// param_sync_fifo_pkg
//   Shared definitions for the parametrised synchronous FIFO.
//   - DEF_WIDTH / DEF_DEPTH : default geometry used by the interface and the top
//   - ptr_w()               : pointer / occupancy width for a given depth
//   - is_pow2()             : elaboration-time depth sanity check
//   - fifo_flags_t          : bundle of status flags decoded from the pointers
package param_sync_fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  // One extra bit over the address so that full and empty are distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_flags_t;

endpackage

// File: rtl/param_sync_fifo_if.sv
// param_sync_fifo_if
//   Handshake/data bundle between a producer/consumer and the FIFO.
//   master : drives wr, din, rd; observes data, occupancy and status pulses
//   slave  : the FIFO itself
//   Signals: wr/din (push), rd (pop), dout/dout_valid (read data),
//            fifo_cnt (occupancy 0..DEPTH), empty/full/almost_empty/almost_full,
//            overflow/underflow (one-cycle error pulses).
interface param_sync_fifo_if
  import param_sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  logic                      wr;
  logic [WIDTH-1:0]          din;
  logic                      rd;
  logic [WIDTH-1:0]          dout;
  logic                      dout_valid;
  logic [ptr_w(DEPTH)-1:0]   fifo_cnt;
  logic                      empty;
  logic                      full;
  logic                      almost_empty;
  logic                      almost_full;
  logic                      overflow;
  logic                      underflow;

  modport master (
    output wr, din, rd,
    input  dout, dout_valid, fifo_cnt, empty, full,
           almost_empty, almost_full, overflow, underflow
  );

  modport slave (
    input  wr, din, rd,
    output dout, dout_valid, fifo_cnt, empty, full,
           almost_empty, almost_full, overflow, underflow
  );
endinterface

// File: rtl/param_sync_fifo_ram.sv
// param_sync_fifo_ram
//   WIDTH x DEPTH register array: one synchronous write port, one
//   asynchronous read port. Contents are deliberately not reset.
//   clk   : clock
//   we    : write enable
//   waddr : write address, wdata : write data
//   raddr : read address,  rdata : read data (combinational)
module param_sync_fifo_ram #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  // Read is combinational, so a same-edge write to the read address is seen
  // only after the edge: a pop at full captures the old word.
  assign rdata = mem_reg[raddr];
endmodule

// File: rtl/param_sync_fifo.sv
// param_sync_fifo
//   Parametrised single-clock FIFO with almost-full/almost-empty thresholds,
//   overflow/underflow pulses, read-valid strobe and optional FWFT output.
//   clk : clock (rising edge)
//   rst : synchronous active-high reset (pointers, flags, output registers)
//   bus : param_sync_fifo_if.slave (wr/din/rd in; dout, dout_valid,
//         fifo_cnt, empty, full, almost_empty, almost_full, overflow,
//         underflow out)
module param_sync_fifo
  import param_sync_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input logic              clk,
  input logic              rst,
  param_sync_fifo_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ptr_w(DEPTH);

  generate
    if (!is_pow2(DEPTH)) begin : g_bad_depth
      $error("param_sync_fifo: DEPTH must be a power of two >= 2");
    end
    if (!((AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH))) begin : g_bad_thresh
      $error("param_sync_fifo: need AE_THRESH < AF_THRESH <= DEPTH");
    end
  endgenerate

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] cnt;
  fifo_flags_t      flags;
  logic             rd_acc, wr_acc;
  logic             overflow_reg, underflow_reg;
  logic [WIDTH-1:0] ram_rdata;

  // Pointers carry one wrap bit, so the modulo difference is the occupancy.
  assign cnt = wr_ptr_reg - rd_ptr_reg;

  always_comb begin
    flags.empty        = (cnt == '0);
    flags.full         = (cnt == PTR_W'(DEPTH));
    flags.almost_empty = (int'(cnt) <= AE_THRESH);
    flags.almost_full  = (int'(cnt) >= AF_THRESH);
  end

  // A pop in the same cycle frees a slot, so a write at full is still taken.
  assign rd_acc = bus.rd & ~flags.empty;
  assign wr_acc = bus.wr & (~flags.full | rd_acc);

  assign wr_ptr_next = wr_ptr_reg + PTR_W'(wr_acc);
  assign rd_ptr_next = rd_ptr_reg + PTR_W'(rd_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      overflow_reg  <= bus.wr & ~wr_acc;
      underflow_reg <= bus.rd & flags.empty;
    end
  end

  param_sync_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc & ~rst),
    .waddr (wr_ptr_reg[ADDR_W-1:0]),
    .wdata (bus.din),
    .raddr (rd_ptr_reg[ADDR_W-1:0]),
    .rdata (ram_rdata)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented directly; valid whenever something is stored.
      assign bus.dout       = ram_rdata;
      assign bus.dout_valid = ~flags.empty;
    end else begin : g_std
      logic [WIDTH-1:0] dout_reg;
      logic             dout_valid_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          dout_reg       <= '0;
          dout_valid_reg <= 1'b0;
        end else begin
          dout_valid_reg <= rd_acc;
          if (rd_acc) begin
            dout_reg <= ram_rdata;
          end
        end
      end

      assign bus.dout       = dout_reg;
      assign bus.dout_valid = dout_valid_reg;
    end
  endgenerate

  assign bus.fifo_cnt     = cnt;
  assign bus.empty        = flags.empty;
  assign bus.full         = flags.full;
  assign bus.almost_empty = flags.almost_empty;
  assign bus.almost_full  = flags.almost_full;
  assign bus.overflow     = overflow_reg;
  assign bus.underflow    = underflow_reg;
endmodule
